// File: rtl/lane_pkg.sv
// Shared definitions for the lane permutation pipeline.
// Mode encodings travel with each word through the pipe.
package lane_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_PASS  = 2'b00,
        MODE_REV   = 2'b01,
        MODE_HSWAP = 2'b10,
        MODE_ROTL  = 2'b11
    } mode_t;

endpackage

// File: rtl/lane_permute.sv
// Combinational lane permutation: each output lane selects one input lane.
// Rotation moves lanes toward the MSB by rot positions.
module lane_permute
    import lane_pkg::*;
#(
    parameter int LANE_W = 4,
    parameter int LANES  = 4,
    localparam int DATA_W = LANE_W * LANES,
    localparam int RW     = $clog2(LANES)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [MODE_W-1:0] mode,
    input  logic [RW-1:0]     rot,
    output logic [DATA_W-1:0] perm
);

    function automatic logic [RW-1:0] src_lane(
        input logic [MODE_W-1:0] m,
        input int                j,
        input logic [RW-1:0]     r
    );
        int s;
        s = j;
        unique case (mode_t'(m))
            MODE_PASS:  s = j;
            MODE_REV:   s = LANES - 1 - j;
            MODE_HSWAP: s = (j + LANES / 2) % LANES;
            MODE_ROTL:  s = (j + LANES - (int'(r) % LANES)) % LANES;
        endcase
        return RW'(s);
    endfunction

    logic [LANE_W-1:0] lane [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane[i] = data[i*LANE_W +: LANE_W];
        assign perm[i*LANE_W +: LANE_W] = lane[src_lane(mode, i, rot)];
    end

endmodule

// File: rtl/lane_permute_pipe.sv
// Two-stage valid/ready lane permuter with a wrapping transfer counter.
// Stage 1 captures word+mode+rot; stage 2 holds the permuted result.
module lane_permute_pipe
    import lane_pkg::*;
#(
    parameter int LANE_W = 4,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16,
    localparam int DATA_W = LANE_W * LANES,
    localparam int RW     = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    input  logic [RW-1:0]     in_rot,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  xfer_cnt
);

    if (LANES < 2 || (LANES % 2) != 0) begin : g_bad_lanes
        $fatal(1, "lane_permute_pipe: LANES must be even and >= 2");
    end

    logic [DATA_W-1:0] s1_data;
    logic [MODE_W-1:0] s1_mode;
    logic [RW-1:0]     s1_rot;
    logic              s1_valid;
    logic [DATA_W-1:0] s2_data;
    logic              s2_valid;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] perm;

    logic s2_load;
    logic accept;
    logic xfer;

    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;
    assign xfer     = s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= '0;
            s1_rot   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_mode  <= in_mode;
            s1_rot   <= in_rot;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    lane_permute #(
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) u_permute (
        .data (s1_data),
        .mode (s1_mode),
        .rot  (s1_rot),
        .perm (perm)
    );

    // A load while the old word leaves keeps s2_valid set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            s2_data  <= perm;
        end else if (xfer) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (xfer) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign out_data  = s2_data;
    assign out_valid = s2_valid;
    assign xfer_cnt  = cnt;

endmodule

// File: doc/lane_permute_pipe.md
Name: lane_permute_pipe

Overview:
- Parametrised, pipelined successor to the fixed 16-bit half-swap rearranger.
- Splits a word into LANES lanes of LANE_W bits each and applies a run-time-selected lane permutation: pass, reverse, half-swap or rotate.
- Has a 2-stage valid/ready pipeline with full backpressure, so it can sit inline in any streaming datapath between a producer and a consumer.
- Keeps a wrap-around count of completed output transfers for debug.

Parameters:
- LANE_W, 4, bits per lane (4 = nibble, 8 = byte).
- LANES, 4, number of lanes; must be even and >= 2. DATA_W = LANE_W*LANES; RW = clog2(LANES).
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  DATA_W  input word; lane i = in_data[i*LANE_W +: LANE_W].
- in_mode  input  2  00 pass, 01 reverse lanes, 10 swap halves, 11 rotate left.
- in_rot  input  RW  rotate amount in lanes; used only in mode 11.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts a word this cycle.
- out_data  output  DATA_W  permuted word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word.
- xfer_cnt  output  CNT_W  number of out_valid&&out_ready transfers, wraps.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-low, rst_n. All state is sampled on the rising edge of clk while rst_n=0.
- Reset values:
  - s1_valid = s2_valid = 0, so out_valid = 0.
  - out_data = 0, xfer_cnt = 0.
  - in_ready = 1 combinationally once rst_n=1.
- Stage 1 registers in_data, in_mode and in_rot, plus s1_valid.
- Stage 2 registers the permuted word, plus s2_valid.
- out_data and out_valid come straight from the stage 2 registers; no combinational path from in_data to out_data.
- Handshake:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_load (combinational; depends on out_ready).
  - Input accepted when in_valid && in_ready. Output transferred when out_valid && out_ready.
- Latency: 2 cycles from acceptance to out_valid when out_ready is held high. Throughput is 1 word per cycle.
- Stage update rules:
  - Stage 1 loads on accept and clears s1_valid when s2_load occurs without a new accept.
  - Stage 2 loads on s2_load. It clears s2_valid on an output transfer with no s2_load.
  - Simultaneous output transfer and s2_load: the new word replaces the old one and s2_valid stays 1.
- Stall: with out_ready=0 and both stages full, in_ready=0. out_data and out_valid hold stable until the transfer; no word is lost or duplicated.
- Permutation, where out lane j takes a given input lane:
  - 00: lane j.
  - 01: lane LANES-1-j.
  - 10: lane (j + LANES/2) mod LANES.
  - 11: lane (j - in_rot) mod LANES. Lanes move toward the MSB; in_rot=0 behaves as pass.
- Mode and rot are captured with their data word, so a mode change mid-stream affects only words accepted after the change.
- xfer_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: both stages are flushed and in-flight words discarded; the counter returns to 0 the same edge.
- Elaboration: LANES odd or < 2 is a fatal error.

Decomposition:
- Shared package, lane_pkg:
  - Mode constants MODE_PASS=2'b00, MODE_REV=2'b01, MODE_HSWAP=2'b10, MODE_ROTL=2'b11.
  - A mode_t typedef.
- Sub-module lane_permute: purely combinational (data, mode, rot) -> permuted word, parametrised by LANE_W and LANES. The top instantiates it between stage 1 and stage 2, and the bench reuses it as the reference model.

Test Plan (defaults LANE_W=4, LANES=4 unless noted):
- Reset: hold rst_n=0 for 3 cycles, then release -> out_valid=0, out_data=0x0000, xfer_cnt=0, in_ready=1.
- Modes, out_ready=1, one word per cycle:
  - 0x1234/00 -> 0x1234.
  - 0x1234/01 -> 0x4321.
  - 0x1234/10 -> 0x3412.
  - 0x1234/11, rot=1 -> 0x2341.
  - Each appears 2 cycles after acceptance, back-to-back; xfer_cnt=4 afterwards.
- Backpressure:
  - Stream 0x0001..0x0005 in mode 00 with out_ready=0 -> in_ready drops after 2 accepts and out_data holds 0x0001.
  - Then raise out_ready -> 0x0001..0x0005 delivered in order, no gaps or duplicates.
- Byte lanes, LANE_W=8, LANES=4, in 0xAABBCCDD:
  - mode 01 -> 0xDDCCBBAA.
  - mode 10 -> 0xCCDDAABB.
  - mode 11, rot=3 -> 0xDDAABBCC.
- Counter wrap, CNT_W=4: 17 transfers -> xfer_cnt reads 15 then 0 then 1.
- Reset mid-stream: assert rst_n=0 with both stages full -> next cycle out_valid=0 and xfer_cnt=0; the first word accepted after release is the first word output.
